// File: rtl/alu_tr_sequencer_pkg.sv
// Shared definitions for the temporal-redundancy ALU sequencer:
// FSM state encoding, the 33-bit vote word and the ALU control codes.
package alu_tr_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        P0   = 3'd1,
        P1   = 3'd2,
        P2   = 3'd3,
        VOTE = 3'd4,
        RSP  = 3'd5
    } state_t;

    // {zero, result} as produced by one ALU pass
    typedef logic [32:0] vote_word_t;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // Flip the selected bits of a captured word when injection is enabled
    function automatic vote_word_t apply_injection(input vote_word_t word,
                                                   input logic       enable,
                                                   input vote_word_t mask);
        return enable ? (word ^ mask) : word;
    endfunction

endpackage

// File: rtl/alu_m.sv
// Single-lane 32-bit ALU shared by the datapath: AND, OR, ADD, SUB, SLT.
module alu_m
    import alu_tr_sequencer_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  alucont,
    output logic [31:0] result,
    output logic        zero
);

    logic [31:0] diff;

    assign diff = a - b;

    // Select the operation; SLT uses the sign of a-b
    always_comb begin
        result = 32'd0;
        case (alucont)
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_ADD: result = a + b;
            ALU_SUB: result = diff;
            ALU_SLT: result = {31'd0, diff[31]};
            default: result = 32'd0;
        endcase
    end

    assign zero = (result == 32'd0);

endmodule

// File: rtl/alu_tr_sequencer_voter.sv
// Three-way voter over 33-bit {zero,result} words: equality detection,
// majority-word selection and bitwise majority for the fault fallback.
module tr_voter3
    import alu_tr_sequencer_pkg::*;
(
    input  vote_word_t w0,
    input  vote_word_t w1,
    input  vote_word_t w2,
    output logic       all_eq,
    output logic       pair_ok,
    output vote_word_t maj_word,
    output vote_word_t bit_maj
);

    logic eq01;
    logic eq02;
    logic eq12;

    assign eq01 = (w0 == w1);
    assign eq02 = (w0 == w2);
    assign eq12 = (w1 == w2);

    // Pick the word shared by at least two passes; w1 covers the w1==w2 case
    always_comb begin
        all_eq   = eq01 & eq02;
        pair_ok  = eq01 | eq02 | eq12;
        maj_word = (eq01 | eq02) ? w0 : w1;
        bit_maj  = (w0 & w1) | (w0 & w2) | (w1 & w2);
    end

endmodule

// File: rtl/alu_tr_sequencer.sv
// Temporal-redundancy controller: runs one operation three times on a
// shared ALU, votes on the results, retries on total disagreement and
// returns a voted result with corrected/fault status and counters.
module alu_tr_sequencer
    import alu_tr_sequencer_pkg::*;
#(
    parameter int MAX_RETRY = 2,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    input  logic [2:0]       req_alucont,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_result,
    output logic             rsp_zero,
    output logic             rsp_corrected,
    output logic             rsp_fault,
    output logic [CNT_W-1:0] corr_count,
    output logic [CNT_W-1:0] fault_count,
    input  logic [2:0]       inj_passes,
    input  logic [32:0]      inj_mask
);

    localparam logic [2:0] RETRY_LIMIT = 3'(MAX_RETRY);

    state_t      state;
    state_t      state_next;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [2:0]  op_cont;
    logic [2:0]  retry_cnt;
    vote_word_t  w0;
    vote_word_t  w1;
    vote_word_t  w2;
    logic [31:0] alu_result;
    logic        alu_zero;
    vote_word_t  alu_word;
    logic        all_eq;
    logic        pair_ok;
    vote_word_t  maj_word;
    vote_word_t  bit_maj;
    logic        accept;
    logic        retry_now;

    alu_m u_alu (
        .a       (op_a),
        .b       (op_b),
        .alucont (op_cont),
        .result  (alu_result),
        .zero    (alu_zero)
    );

    tr_voter3 u_voter (
        .w0       (w0),
        .w1       (w1),
        .w2       (w2),
        .all_eq   (all_eq),
        .pair_ok  (pair_ok),
        .maj_word (maj_word),
        .bit_maj  (bit_maj)
    );

    assign alu_word  = {alu_zero, alu_result};
    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RSP);
    assign accept    = req_valid & req_ready;
    assign retry_now = (state == VOTE) & ~pair_ok & (retry_cnt < RETRY_LIMIT);

    // Next-state: three passes, vote, then retry or hold the response
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_valid) state_next = P0;
            P0:      state_next = P1;
            P1:      state_next = P2;
            P2:      state_next = VOTE;
            VOTE:    state_next = retry_now ? P0 : RSP;
            RSP:     if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Latch the request operands and track how many reruns have been used
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_a      <= 32'd0;
            op_b      <= 32'd0;
            op_cont   <= 3'd0;
            retry_cnt <= 3'd0;
        end else if (accept) begin
            op_a      <= req_a;
            op_b      <= req_b;
            op_cont   <= req_alucont;
            retry_cnt <= 3'd0;
        end else if (retry_now) begin
            retry_cnt <= retry_cnt + 3'd1;
        end
    end

    // Capture each pass result, with optional per-pass fault injection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w0 <= '0;
            w1 <= '0;
            w2 <= '0;
        end else begin
            case (state)
                P0: w0 <= apply_injection(alu_word, inj_passes[0], inj_mask);
                P1: w1 <= apply_injection(alu_word, inj_passes[1], inj_mask);
                P2: w2 <= apply_injection(alu_word, inj_passes[2], inj_mask);
                default: ;
            endcase
        end
    end

    // Register the voted response and bump the saturating status counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_result    <= 32'd0;
            rsp_zero      <= 1'b0;
            rsp_corrected <= 1'b0;
            rsp_fault     <= 1'b0;
            corr_count    <= '0;
            fault_count   <= '0;
        end else if ((state == VOTE) && !retry_now) begin
            if (all_eq) begin
                {rsp_zero, rsp_result} <= w0;
                rsp_corrected          <= 1'b0;
                rsp_fault              <= 1'b0;
            end else if (pair_ok) begin
                {rsp_zero, rsp_result} <= maj_word;
                rsp_corrected          <= 1'b1;
                rsp_fault              <= 1'b0;
                if (corr_count != '1) corr_count <= corr_count + 1'b1;
            end else begin
                {rsp_zero, rsp_result} <= bit_maj;
                rsp_corrected          <= 1'b0;
                rsp_fault              <= 1'b1;
                if (fault_count != '1) fault_count <= fault_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_tr_sequencer.sv
// Directed bench for alu_tr_sequencer: plain ops, single-pass correction,
// persistent disagreement leading to fault, back-pressure and mid-op reset.
module tb_alu_tr_sequencer;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [2:0]  req_alucont;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_zero;
    logic        rsp_corrected;
    logic        rsp_fault;
    logic [15:0] corr_count;
    logic [15:0] fault_count;
    logic [2:0]  inj_passes;
    logic [32:0] inj_mask;

    int total = 0;
    int bad   = 0;
    int edges = 0;

    alu_tr_sequencer #(.MAX_RETRY(2), .CNT_W(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_a         (req_a),
        .req_b         (req_b),
        .req_alucont   (req_alucont),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_result    (rsp_result),
        .rsp_zero      (rsp_zero),
        .rsp_corrected (rsp_corrected),
        .rsp_fault     (rsp_fault),
        .corr_count    (corr_count),
        .fault_count   (fault_count),
        .inj_passes    (inj_passes),
        .inj_mask      (inj_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [32:0] observed,
                               input logic [32:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Present one request and let it be accepted on the next rising edge
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                 input logic [2:0] op);
        @(negedge clk);
        req_valid   = 1'b1;
        req_a       = a;
        req_b       = b;
        req_alucont = op;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    // Count rising edges after the accepting edge until rsp_valid shows up
    task automatic waitRsp(output int n);
        n = 0;
        while (rsp_valid !== 1'b1 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic checkResponse(input string tag, input logic [31:0] res,
                                 input logic z, input logic corr, input logic flt);
        checkOutput({tag, "_result"}, 33'(rsp_result), 33'(res));
        checkOutput({tag, "_zero"}, 33'(rsp_zero), 33'(z));
        checkOutput({tag, "_corrected"}, 33'(rsp_corrected), 33'(corr));
        checkOutput({tag, "_fault"}, 33'(rsp_fault), 33'(flt));
    endtask

    // With rsp_ready high the handshake edge returns the block to IDLE
    task automatic checkRelease(input string tag);
        @(posedge clk);
        #1;
        checkOutput({tag, "_rsp_valid_drop"}, 33'(rsp_valid), 33'd0);
        checkOutput({tag, "_req_ready_back"}, 33'(req_ready), 33'd1);
    endtask

    initial begin
        reset       = 1'b1;
        req_valid   = 1'b0;
        req_a       = 32'd0;
        req_b       = 32'd0;
        req_alucont = 3'd0;
        rsp_ready   = 1'b1;
        inj_passes  = 3'd0;
        inj_mask    = 33'd0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_req_ready", 33'(req_ready), 33'd1);
        checkOutput("reset_rsp_valid", 33'(rsp_valid), 33'd0);
        checkOutput("reset_rsp_result", 33'(rsp_result), 33'd0);
        checkOutput("reset_corr_count", 33'(corr_count), 33'd0);
        checkOutput("reset_fault_count", 33'(fault_count), 33'd0);
        @(negedge clk);
        reset = 1'b0;

        $display("[TB] ADD 5+7");
        applyStimulus(32'd5, 32'd7, 3'b010);
        waitRsp(edges);
        checkOutput("add_latency", 33'(edges), 33'd4);
        checkResponse("add", 32'd12, 1'b0, 1'b0, 1'b0);
        checkRelease("add");

        $display("[TB] SUB 5-5");
        applyStimulus(32'd5, 32'd5, 3'b110);
        waitRsp(edges);
        checkOutput("sub_latency", 33'(edges), 33'd4);
        checkResponse("sub", 32'd0, 1'b1, 1'b0, 1'b0);
        checkRelease("sub");

        $display("[TB] SLT 3<5");
        applyStimulus(32'd3, 32'd5, 3'b111);
        waitRsp(edges);
        checkResponse("slt", 32'd1, 1'b0, 1'b0, 1'b0);
        checkRelease("slt");

        $display("[TB] AND f0&0f");
        applyStimulus(32'h0000_00F0, 32'h0000_000F, 3'b000);
        waitRsp(edges);
        checkResponse("and", 32'd0, 1'b1, 1'b0, 1'b0);
        checkRelease("and");

        $display("[TB] ADD with pass1 corrupted");
        inj_passes = 3'b010;
        inj_mask   = 33'h1;
        applyStimulus(32'd5, 32'd7, 3'b010);
        waitRsp(edges);
        checkOutput("corr_latency", 33'(edges), 33'd4);
        checkResponse("corr", 32'd12, 1'b0, 1'b1, 1'b0);
        checkOutput("corr_count_1", 33'(corr_count), 33'd1);
        checkOutput("corr_fault_count_0", 33'(fault_count), 33'd0);
        checkRelease("corr");
        inj_passes = 3'd0;
        inj_mask   = 33'd0;

        $display("[TB] ADD with three-way disagreement on every attempt");
        applyStimulus(32'd5, 32'd7, 3'b010);
        edges = 0;
        for (int attempt = 0; attempt < 3; attempt++) begin
            @(negedge clk);
            inj_passes = 3'b001;
            inj_mask   = 33'h1;
            @(posedge clk);
            edges++;
            @(negedge clk);
            inj_passes = 3'b010;
            inj_mask   = 33'h2;
            @(posedge clk);
            edges++;
            @(negedge clk);
            inj_passes = 3'b000;
            inj_mask   = 33'h0;
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (attempt < 2) begin
                checkOutput("fault_no_early_rsp", 33'(rsp_valid), 33'd0);
            end
            @(posedge clk);
            edges++;
        end
        #1;
        checkOutput("fault_latency_edges", 33'(edges), 33'd12);
        checkOutput("fault_rsp_valid", 33'(rsp_valid), 33'd1);
        checkResponse("fault", 32'd12, 1'b0, 1'b0, 1'b1);
        checkOutput("fault_count_1", 33'(fault_count), 33'd1);
        checkOutput("fault_corr_count_1", 33'(corr_count), 33'd1);
        checkRelease("fault");

        $display("[TB] back-pressure on response");
        rsp_ready = 1'b0;
        applyStimulus(32'h0000_00F0, 32'h0000_000F, 3'b001);
        waitRsp(edges);
        checkOutput("bp_latency", 33'(edges), 33'd4);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checkOutput("bp_rsp_valid_held", 33'(rsp_valid), 33'd1);
            checkOutput("bp_req_ready_low", 33'(req_ready), 33'd0);
            checkOutput("bp_result_stable", 33'(rsp_result), 33'h0FF);
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        checkRelease("bp");

        $display("[TB] reset during pass 1");
        applyStimulus(32'd9, 32'd4, 3'b110);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #2;
        checkOutput("midrst_rsp_valid", 33'(rsp_valid), 33'd0);
        checkOutput("midrst_req_ready", 33'(req_ready), 33'd1);
        checkOutput("midrst_corr_count", 33'(corr_count), 33'd0);
        checkOutput("midrst_fault_count", 33'(fault_count), 33'd0);
        #2;
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            checkOutput("midrst_no_rsp", 33'(rsp_valid), 33'd0);
        end

        $display("[TB] request after reset");
        applyStimulus(32'd5, 32'd7, 3'b010);
        waitRsp(edges);
        checkOutput("post_latency", 33'(edges), 33'd4);
        checkResponse("post", 32'd12, 1'b0, 1'b0, 1'b0);
        checkOutput("post_corr_count", 33'(corr_count), 33'd0);
        checkRelease("post");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_tr_sequencer.md
Name: alu_tr_sequencer

Overview:
Temporal-redundancy controller for one shared single-lane ALU (alu_m). It accepts one operation at a time over a valid/ready handshake and runs it on the ALU in three consecutive passes. It then votes on the three captured results, retries when no two passes agree, and returns a voted result with correction/fault status. It sits between the datapath's execute-stage request and the ALU, trading latency for area against the spatial N-way voter.

Parameters:
MAX_RETRY, 2, re-executions allowed after a failed vote before declaring fault (0..7)
CNT_W, 16, width of the saturating corrected/fault counters

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high
req_valid  in  1  request present
req_ready  out  1  block can accept (IDLE only)
req_a  in  32  operand a
req_b  in  32  operand b
req_alucont  in  3  ALU control, same encoding as alu_m
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_result  out  32  voted result
rsp_zero  out  1  voted zero flag
rsp_corrected  out  1  at least one pass disagreed but a majority existed
rsp_fault  out  1  no majority after MAX_RETRY retries
corr_count  out  CNT_W  saturating count of corrected responses
fault_count  out  CNT_W  saturating count of fault responses
inj_passes  in  3  one-hot-per-pass fault injection enable (verification hook)
inj_mask  in  33  XOR mask {zero,result} applied to ALU output on enabled passes

Behaviour:
- Reset/clock: reset is asynchronous, active-high; clk is the clock. Reset forces state IDLE, clears all captured words, retry count and counters. Reset values: rsp_valid=0, rsp_* data=0, corr_count=fault_count=0, req_ready=1 (state IDLE).
- States: IDLE, P0, P1, P2, VOTE, RSP.
- IDLE: req_ready=1. On req_valid&req_ready, latch a/b/alucont, clear retry count, go to P0.
- P0/P1/P2: the ALU is driven from the latched operands only. At the end of each state, capture w_k = {zero,result} ^ (inj_passes[k] ? inj_mask : 0). Advance P0->P1->P2->VOTE.
- VOTE, all three words equal: rsp_result/zero = w0, corrected=0, fault=0. Go to RSP.
- VOTE, exactly one word differs (some pair equal): output the agreeing word, corrected=1, corr_count+1 (saturating). Go to RSP.
- VOTE, all three differ and retry<MAX_RETRY: retry+1, go to P0. Captured words are overwritten on the rerun.
- VOTE, all three differ and retry==MAX_RETRY: output the bitwise majority of w0,w1,w2, fault=1, corrected=0, fault_count+1 (saturating). Go to RSP.
- Response fields are registered on the VOTE->RSP edge.
- RSP: rsp_valid=1, with all rsp_* fields stable until rsp_valid&rsp_ready. On that edge go to IDLE and drop rsp_valid. req_ready=0 outside IDLE, so no request is accepted in the same cycle as the response handshake.
- Latency: rsp_valid rises 4 clock edges after the accepting edge with no retry. Each retry adds 4 edges. Minimum issue interval is 6 cycles with rsp_ready held high.
- Counters saturate at all-ones and never wrap.
- Reset mid-operation: the operation is abandoned and no response is emitted.
- inj_passes/inj_mask are sampled each pass, so a persistent injection repeats on every retry. Tie both to 0 in synthesis.

Decomposition:
- Shared package: state encoding, the 33-bit vote word type, and the alucont constants (AND=000, OR=001, ADD=010, SUB=110, SLT=111).
- Natural sub-module: tr_voter3, combinational, 3x33-bit in. Outputs: all_eq, pair_ok, the selected majority word, and the bitwise majority.
- The ALU itself is an existing alu_m instance.

Test Plan:
- ADD a=5 b=7 -> rsp_result=12, zero=0, corrected=0, fault=0; rsp_valid 4 edges after accept.
- SUB a=5 b=5 -> result=0, zero=1. SLT a=3 b=5 -> result=1.
- inj_passes=010, mask=0x1, ADD 5+7 -> result=12, corrected=1, corr_count=1, latency 4.
- MAX_RETRY=2. Inject mask 0x1 on pass0 and mask 0x2 on pass1 (two sequential sub-runs via an injection bench driver), persistently; ADD 5+7 -> words 13/14/12 every attempt. Expect rsp after 12 edges, bitwise majority result=12, fault=1, fault_count=1.
- Hold rsp_ready=0 for 5 cycles after rsp_valid -> rsp fields stable, req_ready=0 throughout; release -> IDLE next edge, req_ready=1.
- Assert reset during P1 -> rsp_valid stays 0, counters 0, req_ready=1; the next request completes normally.
